// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage ALU and the blocks that borrow it.
//   - ALU opcode constants (5-bit ALUCode)
//   - state encoding for the alu_mul_seq multiply sequencer
//   - WIDTH: datapath width of the shared ALU
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int WIDTH  = 16;
   localparam int CODE_W = 5;

   // Full ALU opcode set
   localparam logic [CODE_W-1:0] ALU_NOP  = 5'd0;
   localparam logic [CODE_W-1:0] ALU_AND  = 5'd1;
   localparam logic [CODE_W-1:0] ALU_OR   = 5'd2;
   localparam logic [CODE_W-1:0] ALU_XOR  = 5'd3;
   localparam logic [CODE_W-1:0] ALU_ADD  = 5'd4;
   localparam logic [CODE_W-1:0] ALU_ADDC = 5'd5;
   localparam logic [CODE_W-1:0] ALU_INC  = 5'd6;
   localparam logic [CODE_W-1:0] ALU_SUB  = 5'd7;
   localparam logic [CODE_W-1:0] ALU_DEC  = 5'd8;
   localparam logic [CODE_W-1:0] ALU_SUBC = 5'd9;
   localparam logic [CODE_W-1:0] ALU_SLL  = 5'd10;
   localparam logic [CODE_W-1:0] ALU_SRL  = 5'd11;
   localparam logic [CODE_W-1:0] ALU_SRA  = 5'd12;
   localparam logic [CODE_W-1:0] ALU_PASA = 5'd13;
   localparam logic [CODE_W-1:0] ALU_PASB = 5'd14;
   localparam logic [CODE_W-1:0] ALU_NOT  = 5'd15;

   // Multiply sequencer state encoding
   localparam logic [2:0] MUL_ST_IDLE   = 3'd0;
   localparam logic [2:0] MUL_ST_RUN    = 3'd1;
   localparam logic [2:0] MUL_ST_NEG_LO = 3'd2;
   localparam logic [2:0] MUL_ST_NEG_HI = 3'd3;
   localparam logic [2:0] MUL_ST_DONE   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = MUL_ST_IDLE,
      S_RUN    = MUL_ST_RUN,
      S_NEG_LO = MUL_ST_NEG_LO,
      S_NEG_HI = MUL_ST_NEG_HI,
      S_DONE   = MUL_ST_DONE
   } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Multi-cycle WIDTH x WIDTH shift-add multiplier that borrows the shared
// combinational EX-stage ALU. One ADD per cycle accumulates the partial
// product; the ALU result and carry are shifted into the hi/lo register pair.
//
// Optional feature (macro ALU_MUL_SIGNED_EN): adds input op_signed. Signed
// operands are reduced to magnitudes at capture; a negative result is
// two's-complemented afterwards with a SUB (low half) and SUBC (high half).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request pulse, honoured only in IDLE
//   op_a, op_b         multiplicand / multiplier, captured on accepted start
//   op_signed          (ALU_MUL_SIGNED_EN only) signed request
//   alu_own            sequencer owns the ALU inputs this cycle
//   alu_code/a/b/cf_in ALU drive lines
//   alu_out, alu_cf    combinational ALU result / carry-borrow
//   busy               operation in flight (pipeline stalls on this)
//   done               one-cycle pulse, product valid
//   prod_hi, prod_lo   product halves, held until the next result
//
// All outputs are registered: the ALU drive for a state is computed from the
// next-state values and loaded on the edge that enters that state, so the
// ALU sees it for the whole cycle and no combinational loop through the ALU
// exists.
// -----------------------------------------------------------------------------
module alu_mul_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
`ifdef ALU_MUL_SIGNED_EN
   input  logic             op_signed,
`endif
   output logic             alu_own,
   output logic [4:0]       alu_code,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_cf_in,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_cf,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo
);
   import alu_pkg::*;

   mul_state_e       state_r, state_s;
   logic [CNT_W-1:0] count_r, count_s;
   logic [WIDTH-1:0] hi_r, hi_s, lo_r, lo_s, mcand_r, mcand_s;
   logic [WIDTH-1:0] prod_hi_r, prod_hi_s, prod_lo_r, prod_lo_s;
   logic             own_r, own_s, cf_in_r, cf_in_s, busy_r, busy_s, done_r, done_s;
   logic [4:0]       code_r, code_s;
   logic [WIDTH-1:0] a_r, a_s, b_r, b_s;
   logic             neg_r, neg_s, borrow_r, borrow_s;
   logic             sgn_s;

`ifdef ALU_MUL_SIGNED_EN
   assign sgn_s = op_signed;
`else
   assign sgn_s = 1'b0;
`endif

   // Two's-complement magnitude of a signed operand; unsigned passes through
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      if (sgn && v[WIDTH-1]) begin
         mag = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         mag = v;
      end
   endfunction

   // Next-state and datapath update
   always_comb begin
      state_s  = state_r;
      count_s  = count_r;
      hi_s     = hi_r;
      lo_s     = lo_r;
      mcand_s  = mcand_r;
      neg_s    = neg_r;
      borrow_s = borrow_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               mcand_s  = mag(op_a, sgn_s);
               lo_s     = mag(op_b, sgn_s);
               hi_s     = '0;
               count_s  = '0;
               neg_s    = sgn_s & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
               borrow_s = 1'b0;
               state_s  = S_RUN;
            end else begin
               state_s  = S_IDLE;
            end
         end
         S_RUN: begin
            // Carry-out becomes the new MSB; the sum's LSB drops into lo
            hi_s    = {alu_cf, alu_out[WIDTH-1:1]};
            lo_s    = {alu_out[0], lo_r[WIDTH-1:1]};
            count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            // Last iteration is the one that starts with count at WIDTH-1
            if (count_r == CNT_W'(WIDTH-1)) begin
               state_s = neg_r ? S_NEG_LO : S_DONE;
            end else begin
               state_s = S_RUN;
            end
         end
`ifdef ALU_MUL_SIGNED_EN
         S_NEG_LO: begin
            lo_s     = alu_out;
            borrow_s = alu_cf;
            state_s  = S_NEG_HI;
         end
         S_NEG_HI: begin
            hi_s    = alu_out;
            state_s = S_DONE;
         end
`endif
         S_DONE: begin
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Output decode for the state being entered
   always_comb begin
      own_s     = 1'b0;
      code_s    = ALU_NOP;
      a_s       = '0;
      b_s       = '0;
      cf_in_s   = 1'b0;
      busy_s    = 1'b0;
      done_s    = 1'b0;
      prod_hi_s = prod_hi_r;
      prod_lo_s = prod_lo_r;
      case (state_s)
         S_RUN: begin
            own_s  = 1'b1;
            code_s = ALU_ADD;
            a_s    = hi_s;
            b_s    = lo_s[0] ? mcand_s : '0;
            busy_s = 1'b1;
         end
         S_NEG_LO: begin
            own_s  = 1'b1;
            code_s = ALU_SUB;
            b_s    = lo_s;
            busy_s = 1'b1;
         end
         S_NEG_HI: begin
            own_s   = 1'b1;
            code_s  = ALU_SUBC;
            b_s     = hi_s;
            cf_in_s = borrow_s;
            busy_s  = 1'b1;
         end
         S_DONE: begin
            done_s    = 1'b1;
            prod_hi_s = hi_s;
            prod_lo_s = lo_s;
         end
         default: begin
            own_s = 1'b0;
         end
      endcase
   end

   // State, datapath and registered output update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= S_IDLE;
         count_r   <= '0;
         hi_r      <= '0;
         lo_r      <= '0;
         mcand_r   <= '0;
         neg_r     <= 1'b0;
         borrow_r  <= 1'b0;
         prod_hi_r <= '0;
         prod_lo_r <= '0;
         own_r     <= 1'b0;
         code_r    <= ALU_NOP;
         a_r       <= '0;
         b_r       <= '0;
         cf_in_r   <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         count_r   <= count_s;
         hi_r      <= hi_s;
         lo_r      <= lo_s;
         mcand_r   <= mcand_s;
         neg_r     <= neg_s;
         borrow_r  <= borrow_s;
         prod_hi_r <= prod_hi_s;
         prod_lo_r <= prod_lo_s;
         own_r     <= own_s;
         code_r    <= code_s;
         a_r       <= a_s;
         b_r       <= b_s;
         cf_in_r   <= cf_in_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
      end
   end

   assign alu_own   = own_r;
   assign alu_code  = code_r;
   assign alu_a     = a_r;
   assign alu_b     = b_r;
   assign alu_cf_in = cf_in_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign prod_hi   = prod_hi_r;
   assign prod_lo   = prod_lo_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_seq
// Self-checking bench for alu_mul_seq. Models the shared ALU combinationally
// and checks products against plain integer multiplication.
// Build with +define+ALU_MUL_SIGNED_EN to also exercise the signed path.
// -----------------------------------------------------------------------------
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] op_a, op_b;
`ifdef ALU_MUL_SIGNED_EN
   logic        op_signed;
`endif
   logic        alu_own;
   logic [4:0]  alu_code;
   logic [15:0] alu_a, alu_b;
   logic        alu_cf_in;
   logic [15:0] alu_out;
   logic        alu_cf;
   logic        busy, done;
   logic [15:0] prod_hi, prod_lo;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_mul_seq #(.WIDTH(16), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
`ifdef ALU_MUL_SIGNED_EN
      .op_signed(op_signed),
`endif
      .alu_own(alu_own), .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b),
      .alu_cf_in(alu_cf_in), .alu_out(alu_out), .alu_cf(alu_cf),
      .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo)
   );

   // Shared ALU model: 17-bit {carry/borrow, result}
   logic [16:0] alu_res;
   always_comb begin
      alu_res = 17'd0;
      case (alu_code)
         5'd4:    alu_res = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cf_in};
         5'd7:    alu_res = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, alu_cf_in};
         5'd9:    alu_res = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, alu_cf_in};
         default: alu_res = 17'd0;
      endcase
   end
   assign alu_out = alu_res[15:0];
   assign alu_cf  = alu_res[16];

   // One operation from a negedge: lat = cycles from accept to done (-1 = none)
   task automatic do_run(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                         output int lat, output int busy_n, output int done_n,
                         output int own_n, output int nzb_n, output logic [31:0] prod);
      op_a = a; op_b = b; start = 1'b1;
`ifdef ALU_MUL_SIGNED_EN
      op_signed = sgn;
`else
      if (sgn) $display("note: signed request ignored in unsigned build");
`endif
      lat = -1; busy_n = 0; done_n = 0; own_n = 0; nzb_n = 0; prod = 32'd0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) busy_n++;
         if (alu_own) own_n++;
         if (alu_own && alu_b != 16'd0) nzb_n++;
         if (done) begin
            done_n++;
            if (lat < 0) begin
               lat  = k;
               prod = {prod_hi, prod_lo};
            end
         end
         if (lat >= 0 && k >= lat + 2) break;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op_a = 16'd0; op_b = 16'd0;
`ifdef ALU_MUL_SIGNED_EN
      op_signed = 1'b0;
`endif
      #12;
      n_vec++;
      if ({busy, done, alu_own, alu_cf_in} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags got %b want 0000", {busy, done, alu_own, alu_cf_in});
      end
      n_vec++;
      if ({alu_code, alu_a, alu_b} !== 37'd0) begin
         n_err++; $display("FAIL reset_alu got code=%0d a=%h b=%h want 0", alu_code, alu_a, alu_b);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({prod_hi, prod_lo, busy, done} !== 34'd0) begin
         n_err++; $display("FAIL reset_prod got %h busy=%b done=%b want 0", {prod_hi, prod_lo}, busy, done);
      end
   endtask

   task automatic test_directed(input logic [15:0] a, input logic [15:0] b, input string nm);
      int lat, bn, dn, on, nz; logic [31:0] p, e;
      e = {16'd0, a} * {16'd0, b};
      do_run(a, b, 1'b0, lat, bn, dn, on, nz, p);
      n_vec++;
      if (p !== e) begin n_err++; $display("FAIL %s_prod got %h want %h", nm, p, e); end
      n_vec++;
      if (lat !== 16) begin n_err++; $display("FAIL %s_latency got %0d want 16", nm, lat); end
      n_vec++;
      if (bn !== 16) begin n_err++; $display("FAIL %s_busy_cycles got %0d want 16", nm, bn); end
      n_vec++;
      if (dn !== 1) begin n_err++; $display("FAIL %s_done_count got %0d want 1", nm, dn); end
      n_vec++;
      if (on !== 16) begin n_err++; $display("FAIL %s_own_cycles got %0d want 16", nm, on); end
      if (b == 16'd0) begin
         n_vec++;
         if (nz !== 0) begin n_err++; $display("FAIL %s_alu_b_zero got %0d nonzero cycles want 0", nm, nz); end
      end
   endtask

   task automatic test_random_unsigned();
      int lat, bn, dn, on, nz; logic [31:0] p, e; logic [15:0] a, b;
      for (int i = 0; i < 12; i++) begin
         a = 16'($urandom); b = 16'($urandom);
         e = {16'd0, a} * {16'd0, b};
         do_run(a, b, 1'b0, lat, bn, dn, on, nz, p);
         n_vec++;
         if (p !== e || lat !== 16) begin
            n_err++; $display("FAIL rand_%0d got %h lat %0d want %h lat 16 (a=%h b=%h)", i, p, lat, e, a, b);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat1 = -1, lat2 = -1, dn_first = 0;
      logic [31:0] p1 = 32'd0, p2 = 32'd0;
      logic b17 = 1'b1, b18 = 1'b0;
      op_a = 16'd7; op_b = 16'd9; start = 1'b1;
`ifdef ALU_MUL_SIGNED_EN
      op_signed = 1'b0;
`endif
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k < 16) begin op_a = 16'($urandom); op_b = 16'($urandom); end
         if (k == 16) begin op_a = 16'd11; op_b = 16'd13; end
         if (k == 18) start = 1'b0;
         if (k == 17) b17 = busy;
         if (k == 18) b18 = busy;
         if (done) begin
            if (k < 34) dn_first++;
            if (lat1 < 0) begin lat1 = k; p1 = {prod_hi, prod_lo}; end
            else if (lat2 < 0) begin lat2 = k; p2 = {prod_hi, prod_lo}; end
         end
      end
      n_vec++;
      if (p1 !== 32'h0000003F || lat1 !== 16) begin
         n_err++; $display("FAIL b2b_first got %h lat %0d want 0000003f lat 16", p1, lat1);
      end
      n_vec++;
      if (dn_first !== 1) begin n_err++; $display("FAIL b2b_done_count got %0d want 1", dn_first); end
      n_vec++;
      if ({b17, b18} !== 2'b01) begin n_err++; $display("FAIL b2b_reaccept busy got %b want 01", {b17, b18}); end
      n_vec++;
      if (p2 !== 32'd143 || lat2 !== 34) begin
         n_err++; $display("FAIL b2b_second got %h lat %0d want 0000008f lat 34", p2, lat2);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bn, dn, on, nz, dn_bad = 0; logic [31:0] p;
      op_a = 16'hABCD; op_b = 16'h4321; start = 1'b1;
`ifdef ALU_MUL_SIGNED_EN
      op_signed = 1'b0;
`endif
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({busy, done, alu_own, alu_cf_in, alu_code, alu_a, alu_b, prod_hi, prod_lo} !== 73'd0) begin
         n_err++; $display("FAIL midreset_async got busy=%b own=%b code=%0d a=%h b=%h prod=%h want 0",
                           busy, alu_own, alu_code, alu_a, alu_b, {prod_hi, prod_lo});
      end
      for (int k = 0; k < 3; k++) begin @(negedge clk); if (done) dn_bad++; end
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin @(negedge clk); if (done || busy) dn_bad++; end
      n_vec++;
      if (dn_bad !== 0) begin n_err++; $display("FAIL midreset_no_done got %0d active cycles want 0", dn_bad); end
      do_run(16'd2, 16'd2, 1'b0, lat, bn, dn, on, nz, p);
      n_vec++;
      if (p !== 32'd4 || lat !== 16) begin
         n_err++; $display("FAIL midreset_rerun got %h lat %0d want 00000004 lat 16", p, lat);
      end
   endtask

`ifdef ALU_MUL_SIGNED_EN
   task automatic test_signed();
      int lat, bn, dn, on, nz, sa, sb, el; logic [31:0] p, e; logic [15:0] a, b;
      for (int i = 0; i < 10; i++) begin
         case (i)
            0: begin a = 16'hFFFD; b = 16'd5; end
            1: begin a = 16'h8000; b = 16'h8000; end
            default: begin a = 16'($urandom); b = 16'($urandom); end
         endcase
         sa = int'($signed(a)); sb = int'($signed(b));
         e  = 32'(sa * sb);
         el = (a[15] ^ b[15]) ? 18 : 16;
         do_run(a, b, 1'b1, lat, bn, dn, on, nz, p);
         n_vec++;
         if (p !== e || lat !== el) begin
            n_err++; $display("FAIL signed_%0d got %h lat %0d want %h lat %0d (a=%h b=%h)", i, p, lat, e, el, a, b);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed(16'd3, 16'd5, "mul_3x5");
      test_directed(16'hFFFF, 16'hFFFF, "mul_ffff");
      test_directed(16'h1234, 16'h0000, "mul_zero");
      test_random_unsigned();
      test_back_to_back();
      test_reset_mid();
`ifdef ALU_MUL_SIGNED_EN
      test_signed();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
